// File: rtl/msrh_l1d_rd_arbiter_if.sv
// Bundle of requester-side and dcache-side signals around the shared L1D read port.
// The arbiter uses the slave view; the environment driving requesters and the dcache uses the master view.
interface msrh_l1d_rd_arbiter_if #(
    parameter int REQ_NUM = 4,
    parameter int PADDR_W = 56,
    parameter int DATA_W  = 128
);
    // Requesters -> arbiter
    logic [REQ_NUM-1:0]         i_req_valid;
    logic [REQ_NUM-1:0]         i_req_h_pri;
    logic [REQ_NUM*PADDR_W-1:0] i_req_paddr;
    logic [REQ_NUM-1:0]         o_req_gnt;

    // Arbiter -> dcache s0
    logic                       o_s0_valid;
    logic                       o_s0_h_pri;
    logic [PADDR_W-1:0]         o_s0_paddr;

    // Dcache s1 -> arbiter
    logic                       i_s1_hit;
    logic                       i_s1_miss;
    logic                       i_s1_conflict;
    logic [DATA_W-1:0]          i_s1_data;

    // Arbiter -> requesters, s1 response
    logic [REQ_NUM-1:0]         o_resp_valid;
    logic [1:0]                 o_resp_status;
    logic [DATA_W-1:0]          o_resp_data;

    modport master (
        output i_req_valid, i_req_h_pri, i_req_paddr,
        output i_s1_hit, i_s1_miss, i_s1_conflict, i_s1_data,
        input  o_req_gnt, o_s0_valid, o_s0_h_pri, o_s0_paddr,
        input  o_resp_valid, o_resp_status, o_resp_data
    );

    modport slave (
        input  i_req_valid, i_req_h_pri, i_req_paddr,
        input  i_s1_hit, i_s1_miss, i_s1_conflict, i_s1_data,
        output o_req_gnt, o_s0_valid, o_s0_h_pri, o_s0_paddr,
        output o_resp_valid, o_resp_status, o_resp_data
    );
endinterface

// File: rtl/msrh_l1d_rd_arbiter.sv
// Shares one L1D read port among REQ_NUM requesters: s0 selection (starving > h_pri RR > RR),
// one-cycle s1 tracking of the winner and routing of the dcache s1 result back to it.
module msrh_l1d_rd_arbiter #(
    parameter int REQ_NUM   = 4,
    parameter int PADDR_W   = 56,
    parameter int DATA_W    = 128,
    parameter int STARVE_TH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    msrh_l1d_rd_arbiter_if.slave  bus
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = $clog2(STARVE_TH + 1);

    typedef enum logic [1:0] {
        ST_NONE     = 2'b00,
        ST_HIT      = 2'b01,
        ST_MISS     = 2'b10,
        ST_CONFLICT = 2'b11
    } resp_status_t;

    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_starve [REQ_NUM];
    logic [REQ_NUM-1:0] r_s1_oh;
    logic               r_s1_vld;

    logic [REQ_NUM-1:0] w_starving;
    logic [REQ_NUM-1:0] w_hpri_req;
    logic [REQ_NUM-1:0] w_gnt;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [PADDR_W-1:0] w_paddr;
    logic               w_h_pri;
    logic               w_any_req;
    resp_status_t       w_status;

    // Round-robin search: first set bit at or after ptr, wrapping modulo REQ_NUM.
    function automatic logic [REQ_NUM-1:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [REQ_NUM-1:0] pick;
        logic [PTR_W-1:0]   idx;
        pick = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = PTR_W'((int'(ptr) + k) % REQ_NUM);
            if (req[idx] && (pick == '0)) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [REQ_NUM-1:0] lowest_one(input logic [REQ_NUM-1:0] req);
        logic [REQ_NUM-1:0] pick;
        pick = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (req[k] && (pick == '0)) begin
                pick[k] = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            w_starving[i] = bus.i_req_valid[i] && (r_starve[i] == CNT_W'(STARVE_TH));
        end
        w_hpri_req = bus.i_req_valid & bus.i_req_h_pri;
        w_any_req  = |bus.i_req_valid;
    end

    always_comb begin
        if (|w_starving) begin
            w_gnt = lowest_one(w_starving);
        end else if (|w_hpri_req) begin
            w_gnt = rr_pick(w_hpri_req, r_ptr);
        end else begin
            w_gnt = rr_pick(bus.i_req_valid, r_ptr);
        end
    end

    // One-hot grant makes an OR-mux sufficient; everything reads 0 when nobody requests.
    always_comb begin
        w_win_idx = '0;
        w_paddr   = '0;
        w_h_pri   = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_gnt[i]) begin
                w_win_idx = PTR_W'(i);
                w_paddr   = w_paddr | bus.i_req_paddr[i*PADDR_W +: PADDR_W];
                w_h_pri   = w_h_pri | bus.i_req_h_pri[i];
            end
        end
        w_ptr_next = (w_win_idx == PTR_W'(REQ_NUM - 1)) ? '0 : w_win_idx + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr    <= '0;
            r_s1_oh  <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            if (w_any_req) begin
                r_ptr <= w_ptr_next;
            end
            r_s1_oh  <= w_gnt;
            r_s1_vld <= w_any_req;
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is safe to reset in a loop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                r_starve[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (!bus.i_req_valid[i] || w_gnt[i]) begin
                    r_starve[i] <= '0;
                end else if (r_starve[i] < CNT_W'(STARVE_TH)) begin
                    r_starve[i] <= r_starve[i] + CNT_W'(1);
                end
            end
        end
    end

    // Hit outranks conflict, which outranks miss; no flag on a live s1 slot reports NONE.
    always_comb begin
        if (!r_s1_vld) begin
            w_status = ST_NONE;
        end else if (bus.i_s1_hit) begin
            w_status = ST_HIT;
        end else if (bus.i_s1_conflict) begin
            w_status = ST_CONFLICT;
        end else if (bus.i_s1_miss) begin
            w_status = ST_MISS;
        end else begin
            w_status = ST_NONE;
        end
    end

    assign bus.o_req_gnt     = w_gnt;
    assign bus.o_s0_valid    = w_any_req;
    assign bus.o_s0_h_pri    = w_h_pri;
    assign bus.o_s0_paddr    = w_paddr;
    assign bus.o_resp_valid  = r_s1_oh & {REQ_NUM{r_s1_vld}};
    assign bus.o_resp_status = w_status;
    assign bus.o_resp_data   = bus.i_s1_data;

endmodule
